stream_result_checker: RTL and testbench
========================================

Name: stream_result_checker

Overview:
- Synthesizable receiving end of the layer valid/ready output stream (the m_data_out_y side of layer/multi pipelines).
- Holds NUMVALS expected words in an internal RAM loaded over a write port, then consumes the stream as slave.
- Compares every accepted word against the RAM and reports error count, first mismatch index, done and pass.
- Used for on-chip/FPGA self-check of layer chains, in place of the simulation-only bench sink.

Parameters:
WIDTH, 16, data word width (signed)
NUMVALS, 2340, number of words expected per run
ADDRW, $clog2(NUMVALS), RAM address / index width
ERRW, 16, error counter width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
s_data_in_y  input  WIDTH  stream data from DUT master (signed)
s_valid_y  input  1  stream valid from DUT
s_ready_y  output  1  stream ready to DUT
exp_wr_en  input  1  expected-RAM write strobe
exp_wr_addr  input  ADDRW  expected-RAM write address
exp_wr_data  input  WIDTH  expected-RAM write data
start  input  1  one-cycle pulse, begins a run
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE, held until next start
err_count  output  ERRW  mismatches in current/last run, saturating
first_err_valid  output  1  at least one mismatch seen this run
first_err_idx  output  ADDRW  index of first mismatch

Behaviour:
- Reset (reset==0, async): state IDLE; s_ready_y=0, busy=0, done=0, err_count=0, first_err_valid=0, first_err_idx=0, idx=0, compare stage invalid. RAM contents are not reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE: s_ready_y=0. If exp_wr_en, mem[exp_wr_addr]<=exp_wr_data; addresses >= NUMVALS are ignored. start -> RUN with idx=0, err_count=0, first_err_valid=0, first_err_idx=0, done=0.
- RUN/DRAIN: exp_wr_en and start are ignored.
- RUN: s_ready_y=1 (see optional feature). Handshake = s_valid_y && s_ready_y. On handshake, same edge:
  - data_q<=s_data_in_y, exp_q<=mem[idx], idx_q<=idx, cmp_v<=1, idx<=idx+1.
  - With no handshake, cmp_v<=0.
- Compare stage, one cycle after handshake: if cmp_v && data_q!==exp_q, err_count<=err_count+1, saturating at all-ones.
  - If first_err_valid==0 at that point: first_err_valid<=1, first_err_idx<=idx_q.
- Handshake with idx==NUMVALS-1 -> DRAIN. s_ready_y drops in the next cycle, so exactly NUMVALS words are accepted per run.
- DRAIN: s_ready_y=0; last compare executes -> DONE next edge; done=1.
- pass is not a port; external logic uses done && err_count==0.
- Latency: err_count updates one cycle after the offending handshake; done asserts two cycles after the final handshake.
- s_ready_y is a registered output (no combinational path from s_valid_y).
- Reset mid-run aborts immediately to IDLE, outputs per reset; RAM is preserved, so a new start needs no reload.
- start in the same cycle as exp_wr_en in IDLE: the write takes effect and the run begins; the first RAM read occurs on the first handshake, after the write.

Optional Feature:
- Macro RSC_RAND_BACKPRESSURE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset; advances every cycle.
  - In RUN, s_ready_y=lfsr[0] (registered), giving ~50% pseudo-random backpressure for protocol stress.
- Undefined: no LFSR; s_ready_y=1 throughout RUN.

Decomposition:
- Package rsc_pkg: state enum (IDLE, RUN, DRAIN, DONE), LFSR seed and tap constants.
- One sub-module, rsc_exp_mem: single-port write, synchronous-read RAM of NUMVALS x WIDTH. Read address idx, output registered; write enabled only in IDLE/DONE.
- FSM, counters and compare stay in the top module.

Test Plan:
- Load mem[k]=k for NUMVALS=8; start; stream 0..7 with s_valid_y=1 -> 8 handshakes; done two cycles after last; err_count=0; first_err_valid=0.
- Same load; stream with word 3 = 16'h8000 and word 6 = 16'h7FFF -> err_count=2, first_err_valid=1, first_err_idx=3.
- s_valid_y toggling every other cycle plus 10 extra words offered after the 8th -> exactly 8 accepted; s_ready_y=0 from the cycle after the 8th handshake; extra words never consumed.
- Pull reset low during RUN after 4 handshakes -> all outputs zero immediately; a new start with no reload and a correct 8-word stream -> err_count=0.
- exp_wr_en with data 16'hFFFF during RUN -> ignored. Following run still expects k; a stream of k -> err_count=0.
- ERRW=2, 8 mismatching words -> err_count saturates at 3; first_err_idx=0. With RSC_RAND_BACKPRESSURE_EN: s_ready_y follows the LFSR sequence from 16'hACE1; results identical to the non-random run.

Source files
------------

// File: rtl/rsc_pkg.sv
// rsc_pkg: shared types and constants for stream_result_checker.
// Contains the FSM state enum and the LFSR seed/tap constants. The LFSR is used
// only when RSC_RAND_BACKPRESSURE_EN is defined.
package rsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rsc_state_e;

  localparam logic [15:0] LP_LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LP_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LP_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rsc_exp_mem.sv
// rsc_exp_mem: NUMVALS x WIDTH expected-value RAM.
// It has a single write port and a synchronous read port with a registered output.
// Contents are intentionally not reset, so a reset between runs keeps the loaded
// expectations.
module rsc_exp_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2340,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [ADDRW-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [ADDRW-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port: the caller guarantees the address is in range and the state allows writes
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: capture the expected word on the same edge the stream word is accepted
  always_ff @(posedge clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stream_result_checker.sv
// stream_result_checker: receiving end of a layer valid/ready output stream.
// It compares NUMVALS accepted words against an internal expected RAM.
// It reports a saturating error count, the index of the first mismatch, and done.
// Optional macro RSC_RAND_BACKPRESSURE_EN: drives ready from a 16-bit LFSR while running.
// Handshake: a word transfers on a rising edge where s_valid_y && s_ready_y. The source
// may hold or change data while s_ready_y is low. s_ready_y is registered and never
// depends on s_valid_y in the same cycle.
module stream_result_checker
  import rsc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUMVALS = 2340,
  parameter int ADDRW   = $clog2(NUMVALS),
  parameter int ERRW    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  input  logic                    exp_wr_en,
  input  logic [ADDRW-1:0]        exp_wr_addr,
  input  logic [WIDTH-1:0]        exp_wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ERRW-1:0]         err_count,
  output logic                    first_err_valid,
  output logic [ADDRW-1:0]        first_err_idx,
  output logic [1:0]              dbg_state
);

  localparam logic [ADDRW-1:0] LP_LAST    = ADDRW'(NUMVALS - 1);
  localparam logic [ADDRW:0]   LP_NUM_EXT = (ADDRW + 1)'(NUMVALS);

  rsc_state_e               r_state;
  rsc_state_e               w_next_state;
  logic                     r_ready;
  logic                     w_ready_next;
  logic [ADDRW-1:0]         r_idx;
  logic [ADDRW-1:0]         r_idx_q;
  logic signed [WIDTH-1:0]  r_data_q;
  logic                     r_cmp_v;
  logic [ERRW-1:0]          r_err_count;
  logic                     r_first_v;
  logic [ADDRW-1:0]         r_first_idx;
  logic [WIDTH-1:0]         w_exp_q;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_idle_like;
  logic                     w_start;
  logic                     w_mem_we;
  logic                     w_mismatch;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start     = start && w_idle_like;
  assign w_hs        = s_valid_y && r_ready && (r_state == ST_RUN);
  assign w_last      = w_hs && (r_idx == LP_LAST);
  assign w_mem_we    = exp_wr_en && w_idle_like && ({1'b0, exp_wr_addr} < LP_NUM_EXT);
  assign w_mismatch  = r_cmp_v && (r_data_q != w_exp_q);

  rsc_exp_mem #(
    .WIDTH(WIDTH),
    .DEPTH(NUMVALS),
    .ADDRW(ADDRW)
  ) u_exp_mem (
    .clk      (clk),
    .i_wr_en  (w_mem_we),
    .i_wr_addr(exp_wr_addr),
    .i_wr_data(exp_wr_data),
    .i_rd_en  (w_hs),
    .i_rd_addr(r_idx),
    .o_rd_data(w_exp_q)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: DRAIN waits until the final compare has retired
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_RUN;
      ST_RUN:   if (w_last) w_next_state = ST_DRAIN;
      ST_DRAIN: if (!r_cmp_v) w_next_state = ST_DONE;
      ST_DONE:  if (start) w_next_state = ST_RUN;
      default:  w_next_state = ST_IDLE;
    endcase
  end

`ifdef RSC_RAND_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;

  assign w_lfsr_next  = lfsr_next(r_lfsr);
  assign w_ready_next = (w_next_state == ST_RUN) && w_lfsr_next[0];

  // Free-running pseudo-random source for backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= LP_LFSR_SEED;
    else        r_lfsr <= w_lfsr_next;
  end
`else
  assign w_ready_next = (w_next_state == ST_RUN);
`endif

  // Registered ready: drops the cycle after the final handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ready <= 1'b0;
    else        r_ready <= w_ready_next;
  end

  // Capture stage, index counter, and compare/error bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_idx_q     <= '0;
      r_data_q    <= '0;
      r_cmp_v     <= 1'b0;
      r_err_count <= '0;
      r_first_v   <= 1'b0;
      r_first_idx <= '0;
    end else begin
      r_cmp_v <= w_hs;
      if (w_hs) begin
        r_data_q <= s_data_in_y;
        r_idx_q  <= r_idx;
        r_idx    <= r_idx + 1'b1;
      end
      if (w_start) begin
        r_idx       <= '0;
        r_err_count <= '0;
        r_first_v   <= 1'b0;
        r_first_idx <= '0;
      end else if (w_mismatch) begin
        if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        if (!r_first_v) begin
          r_first_v   <= 1'b1;
          r_first_idx <= r_idx_q;
        end
      end
    end
  end

  assign s_ready_y       = r_ready;
  assign busy            = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done            = (r_state == ST_DONE);
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_v;
  assign first_err_idx   = r_first_idx;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_stream_result_checker.sv
// tb_stream_result_checker: table-driven runs plus hand-written corner sequences.
// A per-word scoreboard tracks the expected error count.
// A second instance with ERRW=2 shares the stimulus to exercise counter saturation.
module tb_stream_result_checker;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  s_data_in_y;
  logic          s_valid_y;
  logic          s_ready_y;
  logic          exp_wr_en;
  logic [AW-1:0] exp_wr_addr;
  logic [W-1:0]  exp_wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [15:0]   err_count;
  logic          first_err_valid;
  logic [AW-1:0] first_err_idx;
  logic [1:0]    dbg_state;

  logic          s_ready_y_s;
  logic          busy_s;
  logic          done_s;
  logic [1:0]    err_count_s;
  logic          first_err_valid_s;
  logic [AW-1:0] first_err_idx_s;
  logic [1:0]    dbg_state_s;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_mem [N];
  int           m_idx;
  logic [W-1:0] m_err;
  bit           st1, st2;

  typedef struct {
    logic [7:0] bad;
    bit         toggle;
    int         extra;
    int         err;
    bit         fv;
    int         fidx;
  } vec_t;
  vec_t vecs[5];

  stream_result_checker #(.WIDTH(W), .NUMVALS(N), .ADDRW(AW), .ERRW(16)) dut (
    .clk(clk), .reset(reset), .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y),
    .s_ready_y(s_ready_y), .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr),
    .exp_wr_data(exp_wr_data), .start(start), .busy(busy), .done(done),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .dbg_state(dbg_state)
  );

  stream_result_checker #(.WIDTH(W), .NUMVALS(N), .ADDRW(AW), .ERRW(2)) dut_sat (
    .clk(clk), .reset(reset), .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y),
    .s_ready_y(s_ready_y_s), .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr),
    .exp_wr_data(exp_wr_data), .start(start), .busy(busy_s), .done(done_s),
    .err_count(err_count_s), .first_err_valid(first_err_valid_s),
    .first_err_idx(first_err_idx_s), .dbg_state(dbg_state_s)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_for(input int k, input logic [7:0] bad);
    logic [W-1:0] kv;
    kv = W'(k);
    if (k < N && bad[k]) begin
      if (k == 3) return 16'h8000;
      if (k == 6) return 16'h7FFF;
      return ~kv;
    end
    return kv;
  endfunction

`ifdef RSC_RAND_BACKPRESSURE_EN
  logic [15:0] m_lfsr;
  // Reference LFSR: taps 16,14,13,11, seeded on reset
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end
`endif

  // Scoreboard: push expected count on each handshake, compare two negedges later
  always @(negedge clk) begin
    logic exp_rdy;
    if (!reset) begin
      exp_q.delete();
      st1 = 1'b0;
      st2 = 1'b0;
      m_idx = 0;
      m_err = '0;
    end else begin
      if (st2) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
        else chk("sb_err_count", err_count, exp_q.pop_front());
      end
      if (start) begin
        m_idx = 0;
        m_err = '0;
      end
      st2 = st1;
      st1 = s_valid_y && s_ready_y;
      if (s_valid_y && s_ready_y) begin
        if (m_idx >= N || s_data_in_y !== m_mem[m_idx]) m_err = m_err + 1'b1;
        m_idx++;
        exp_q.push_back(m_err);
      end
`ifdef RSC_RAND_BACKPRESSURE_EN
      exp_rdy = (dbg_state == 2'd1) && m_lfsr[0];
`else
      exp_rdy = (dbg_state == 2'd1);
`endif
      chk("ready_value", s_ready_y, exp_rdy);
    end
  end

  // Driver tasks: all called at posedge+1
  task automatic write_mem(input int a, input logic [W-1:0] d, input bit model);
    exp_wr_en = 1'b1;
    exp_wr_addr = AW'(a);
    exp_wr_data = d;
    if (model) m_mem[a] = d;
    @(posedge clk); #1;
    exp_wr_en = 1'b0;
  endtask

  task automatic do_start(input bit with_wr, input int a, input logic [W-1:0] d);
    start = 1'b1;
    if (with_wr) begin
      exp_wr_en = 1'b1;
      exp_wr_addr = AW'(a);
      exp_wr_data = d;
      m_mem[a] = d;
    end
    @(posedge clk); #1;
    start = 1'b0;
    exp_wr_en = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err_count, 0);
    chk("start_fev_clr", first_err_valid, 0);
  endtask

  task automatic stream(input logic [7:0] bad, input bit toggle, input int extra, input int n_words);
    int sent = 0;
    int cyc = 0;
    int acc_extra = 0;
    bit hs;
    while (sent < n_words && cyc < 300) begin
      s_valid_y = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data_in_y = word_for(sent, bad);
      @(negedge clk);
      hs = s_valid_y && s_ready_y;
      @(posedge clk); #1;
      if (hs) sent++;
      cyc++;
    end
    s_valid_y = 1'b0;
    chk("handshake_count", sent, n_words);
    if (sent < n_words || n_words < N) return;
    for (int k = 0; k < 3 + extra; k++) begin
      s_valid_y = (k < extra);
      s_data_in_y = 16'h5A5A;
      @(negedge clk);
      if (k == 0) chk("ready_drop", s_ready_y, 0);
      if (k == 1) chk("done_early", done, 0);
      if (k == 2) chk("done_latency", done, 1);
      if (s_valid_y && s_ready_y) acc_extra++;
      @(posedge clk); #1;
    end
    s_valid_y = 1'b0;
    chk("extra_accepted", acc_extra, 0);
  endtask

  // Main sequence
  initial begin
    reset = 1'b0;
    s_valid_y = 1'b0;
    s_data_in_y = '0;
    exp_wr_en = 1'b0;
    exp_wr_addr = '0;
    exp_wr_data = '0;
    start = 1'b0;
    for (int k = 0; k < N; k++) m_mem[k] = '0;

    vecs[0] = '{bad: 8'h00, toggle: 1'b0, extra: 0,  err: 0, fv: 1'b0, fidx: 0};
    vecs[1] = '{bad: 8'h48, toggle: 1'b0, extra: 0,  err: 2, fv: 1'b1, fidx: 3};
    vecs[2] = '{bad: 8'h00, toggle: 1'b1, extra: 10, err: 0, fv: 1'b0, fidx: 0};
    vecs[3] = '{bad: 8'hFF, toggle: 1'b0, extra: 0,  err: 8, fv: 1'b1, fidx: 0};
    vecs[4] = '{bad: 8'h81, toggle: 1'b1, extra: 3,  err: 2, fv: 1'b1, fidx: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_ready_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fev", first_err_valid, 0);
    chk("rst_fidx", first_err_idx, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) write_mem(k, W'(k), 1'b1);

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      do_start(1'b0, 0, '0);
      stream(vecs[i].bad, vecs[i].toggle, vecs[i].extra, N);
      chk("run_err_count", err_count, vecs[i].err);
      chk("run_fev", first_err_valid, vecs[i].fv);
      chk("run_fidx", first_err_idx, vecs[i].fidx);
      chk("sat_err_count", err_count_s, (vecs[i].err > 3) ? 3 : vecs[i].err);
      chk("sat_done", done_s, 1);
    end

    // Done is held until the next start
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done, 1);

    // Reset mid-run aborts; RAM survives
    do_start(1'b0, 0, '0);
    stream(8'h0F, 1'b0, 0, 4);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_ready", s_ready_y, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err_count, 0);
    chk("abort_fev", first_err_valid, 0);
    chk("abort_fidx", first_err_idx, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_start(1'b0, 0, '0);
    stream(8'h00, 1'b0, 0, N);
    chk("post_abort_err", err_count, 0);

    // Writes during RUN are ignored (this run and the next)
    do_start(1'b0, 0, '0);
    write_mem(2, 16'hFFFF, 1'b0);
    stream(8'h00, 1'b0, 0, N);
    chk("wr_in_run_err", err_count, 0);
    do_start(1'b0, 0, '0);
    stream(8'h00, 1'b0, 0, N);
    chk("wr_in_run_next_err", err_count, 0);

    // Write in the same cycle as start takes effect before the first read
    write_mem(0, 16'hDEAD, 1'b1);
    do_start(1'b1, 0, 16'h0000);
    stream(8'h00, 1'b0, 0, N);
    chk("start_wr_err", err_count, 0);
    chk("start_wr_fev", first_err_valid, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
